system_sequencer: RTL and testbench

Parametrised top-level run controller for the multi-core processor system. Sequences a full job through these phases:
- Stream-load the instruction RAM.
- Stream-load the data RAM.
- Start and run the processor.
- Stream the result region of data RAM back out.
- Report completion and the execution cycle count.

It owns the address, write-enable and data muxes of both RAMs in every phase. It replaces the fixed idle/execute/finish controller and generalises core count, widths and depths.

---
 rtl/system_sequencer_pkg.sv | 30 +++
 rtl/system_sequencer_ram_mux.sv | 69 ++++++
 rtl/system_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_system_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/system_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// system_sequencer_pkg : sequencer state and RAM port-select encodings  rev 1.0
// ----------------------------------------------------------------------------
package system_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_INS   = 3'd1,
    S_LOAD_DATA  = 3'd2,
    S_EXEC_START = 3'd3,
    S_EXEC_RUN   = 3'd4,
    S_DUMP_RD    = 3'd5,
    S_DUMP_OUT   = 3'd6,
    S_FINISH     = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_PROC = 2'd2,
    SEL_DUMP = 2'd3
  } ram_port_sel_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/system_sequencer_ram_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_ram_mux : selects instruction/data RAM port drivers per phase     rev 1.0
// ----------------------------------------------------------------------------
module seq_ram_mux
  import system_sequencer_pkg::*;
#(
  parameter int INS_WIDTH = 8,
  parameter int DATA_W    = 24,
  parameter int IA_W      = 8,
  parameter int DA_W      = 12,
  parameter int LW        = 12
) (
  input  ram_port_sel_t           ins_sel,
  input  ram_port_sel_t           data_sel,
  input  logic [LW-1:0]           load_addr,
  input  logic                    load_fire,
  input  logic [DATA_W-1:0]       load_data,
  input  logic [IA_W-1:0]         proc_ins_addr,
  input  logic [DA_W-1:0]         proc_data_addr,
  input  logic [DATA_W-1:0]       proc_data_out,
  input  logic                    proc_wr_en,
  input  logic [DA_W-1:0]         dump_addr,
  output logic [IA_W-1:0]         ins_addr,
  output logic                    ins_wr_en,
  output logic [INS_WIDTH-1:0]    ins_din,
  output logic [DA_W-1:0]         data_addr,
  output logic                    data_wr_en,
  output logic [DATA_W-1:0]       data_din
);

  always_comb begin
    ins_addr  = '0;
    ins_wr_en = 1'b0;
    ins_din   = '0;
    case (ins_sel)
      SEL_LOAD: begin
        ins_addr  = load_addr[IA_W-1:0];
        ins_wr_en = load_fire;
        ins_din   = load_data[INS_WIDTH-1:0];
      end
      // The processor only fetches from instruction RAM, never writes it.
      SEL_PROC: ins_addr = proc_ins_addr;
      default: ;
    endcase
  end

  always_comb begin
    data_addr  = '0;
    data_wr_en = 1'b0;
    data_din   = '0;
    case (data_sel)
      SEL_LOAD: begin
        data_addr  = load_addr[DA_W-1:0];
        data_wr_en = load_fire;
        data_din   = load_data;
      end
      SEL_PROC: begin
        data_addr  = proc_data_addr;
        data_wr_en = proc_wr_en;
        data_din   = proc_data_out;
      end
      SEL_DUMP: data_addr = dump_addr;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/system_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// system_sequencer : load / execute / dump run controller for the core array
// rev 1.0
// ----------------------------------------------------------------------------
module system_sequencer
  import system_sequencer_pkg::*;
#(
  parameter int CORE_COUNT     = 2,
  parameter int REG_WIDTH      = 12,
  parameter int INS_WIDTH      = 8,
  parameter int INS_MEM_DEPTH  = 256,
  parameter int DATA_MEM_DEPTH = 4096,
  parameter int CNT_W          = 32
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic                                startN,
  input  logic [$clog2(INS_MEM_DEPTH):0]      ins_len,
  input  logic [$clog2(DATA_MEM_DEPTH):0]     data_len,
  input  logic [$clog2(DATA_MEM_DEPTH)-1:0]   res_base,
  input  logic [$clog2(DATA_MEM_DEPTH):0]     res_len,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CORE_COUNT*REG_WIDTH-1:0]     in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CORE_COUNT*REG_WIDTH-1:0]     out_data,
  output logic                                proc_start,
  input  logic                                proc_ready,
  input  logic                                proc_done,
  input  logic [$clog2(INS_MEM_DEPTH)-1:0]    proc_ins_addr,
  input  logic [$clog2(DATA_MEM_DEPTH)-1:0]   proc_data_addr,
  input  logic [CORE_COUNT*REG_WIDTH-1:0]     proc_data_out,
  input  logic                                proc_wr_en,
  output logic [$clog2(INS_MEM_DEPTH)-1:0]    ins_addr,
  output logic                                ins_wr_en,
  output logic [INS_WIDTH-1:0]                ins_din,
  output logic [$clog2(DATA_MEM_DEPTH)-1:0]   data_addr,
  output logic                                data_wr_en,
  output logic [CORE_COUNT*REG_WIDTH-1:0]     data_din,
  input  logic [CORE_COUNT*REG_WIDTH-1:0]     data_dout,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_W-1:0]                    exec_cycles
);

  localparam int DATA_W = CORE_COUNT * REG_WIDTH;
  localparam int IA_W   = $clog2(INS_MEM_DEPTH);
  localparam int DA_W   = $clog2(DATA_MEM_DEPTH);
  localparam int LW     = max2(IA_W, DA_W);
  localparam int CW     = LW + 1;

  seq_state_t          state_q,    state_d;
  logic [CW-1:0]       cnt_q,      cnt_d;
  logic [IA_W:0]       ins_len_q,  ins_len_d;
  logic [DA_W:0]       data_len_q, data_len_d;
  logic [DA_W-1:0]     res_base_q, res_base_d;
  logic [DA_W:0]       res_len_q,  res_len_d;
  logic [CNT_W-1:0]    exec_q,     exec_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_hold_q, out_hold_d;

  ram_port_sel_t       ins_sel, data_sel;
  logic                load_fire;
  logic [CW-1:0]       cnt_inc;
  logic [DA_W-1:0]     dump_addr;

  assign cnt_inc   = cnt_q + CW'(1);
  assign dump_addr = res_base_q + cnt_q[DA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ins_len_q  <= '0;
      data_len_q <= '0;
      res_base_q <= '0;
      res_len_q  <= '0;
      exec_q     <= '0;
      out_data_q <= '0;
      out_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ins_len_q  <= ins_len_d;
      data_len_q <= data_len_d;
      res_base_q <= res_base_d;
      res_len_q  <= res_len_d;
      exec_q     <= exec_d;
      out_data_q <= out_data_d;
      out_hold_q <= out_hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ins_len_d  = ins_len_q;
    data_len_d = data_len_q;
    res_base_d = res_base_q;
    res_len_d  = res_len_q;
    exec_d     = exec_q;
    out_data_d = out_data_q;
    out_hold_d = out_hold_q;
    ins_sel    = SEL_NONE;
    data_sel   = SEL_NONE;
    load_fire  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    proc_start = 1'b0;

    case (state_q)
      S_IDLE, S_FINISH: begin
        if (!startN) begin
          ins_len_d  = ins_len;
          data_len_d = data_len;
          res_base_d = res_base;
          res_len_d  = res_len;
          exec_d     = '0;
          cnt_d      = '0;
          out_hold_d = 1'b0;
          // Empty load phases are skipped using the live inputs.
          if (ins_len != '0)       state_d = S_LOAD_INS;
          else if (data_len != '0) state_d = S_LOAD_DATA;
          else                     state_d = S_EXEC_START;
        end
      end
      S_LOAD_INS: begin
        in_ready  = 1'b1;
        ins_sel   = SEL_LOAD;
        load_fire = in_valid;
        if (in_valid) begin
          if (cnt_inc == CW'(ins_len_q)) begin
            cnt_d   = '0;
            state_d = (data_len_q != '0) ? S_LOAD_DATA : S_EXEC_START;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_LOAD_DATA: begin
        in_ready  = 1'b1;
        data_sel  = SEL_LOAD;
        load_fire = in_valid;
        if (in_valid) begin
          if (cnt_inc == CW'(data_len_q)) begin
            cnt_d   = '0;
            state_d = S_EXEC_START;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_EXEC_START: begin
        ins_sel  = SEL_PROC;
        data_sel = SEL_PROC;
        if (proc_ready) begin
          proc_start = 1'b1;
          state_d    = S_EXEC_RUN;
        end
      end
      S_EXEC_RUN: begin
        ins_sel  = SEL_PROC;
        data_sel = SEL_PROC;
        if (exec_q != '1) exec_d = exec_q + CNT_W'(1);
        if (proc_done) begin
          cnt_d   = '0;
          state_d = (res_len_q != '0) ? S_DUMP_RD : S_FINISH;
        end
      end
      S_DUMP_RD: begin
        data_sel   = SEL_DUMP;
        out_hold_d = 1'b0;
        state_d    = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        out_valid = 1'b1;
        // RAM data is valid only in the first DUMP_OUT cycle; latch it for stalls.
        if (!out_hold_q) begin
          out_data_d = data_dout;
          out_hold_d = 1'b1;
        end
        if (out_ready) begin
          out_hold_d = 1'b0;
          cnt_d      = cnt_inc;
          state_d    = (cnt_inc == CW'(res_len_q)) ? S_FINISH : S_DUMP_RD;
        end
      end
      default: ;
    endcase
  end

  assign out_data    = out_hold_q ? out_data_q : data_dout;
  assign busy        = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done        = (state_q == S_FINISH);
  assign exec_cycles = exec_q;

  seq_ram_mux #(
    .INS_WIDTH (INS_WIDTH),
    .DATA_W    (DATA_W),
    .IA_W      (IA_W),
    .DA_W      (DA_W),
    .LW        (LW)
  ) u_ram_mux (
    .ins_sel        (ins_sel),
    .data_sel       (data_sel),
    .load_addr      (cnt_q[LW-1:0]),
    .load_fire      (load_fire),
    .load_data      (in_data),
    .proc_ins_addr  (proc_ins_addr),
    .proc_data_addr (proc_data_addr),
    .proc_data_out  (proc_data_out),
    .proc_wr_en     (proc_wr_en),
    .dump_addr      (dump_addr),
    .ins_addr       (ins_addr),
    .ins_wr_en      (ins_wr_en),
    .ins_din        (ins_din),
    .data_addr      (data_addr),
    .data_wr_en     (data_wr_en),
    .data_din       (data_din)
  );

endmodule
`default_nettype wire

// File: tb/tb_system_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_system_sequencer : directed bench with RAM and processor models    rev 1.0
// ----------------------------------------------------------------------------
module tb_system_sequencer;

  localparam int INS_WIDTH      = 8;
  localparam int INS_MEM_DEPTH  = 256;
  localparam int DATA_MEM_DEPTH = 4096;
  localparam int CNT_W          = 32;
  localparam int DATA_W         = 24;
  localparam int IA_W           = 8;
  localparam int DA_W           = 12;
  localparam int DONE_LAT       = 10;

  logic                 clk = 1'b0;
  logic                 rstN = 1'b0;
  logic                 startN = 1'b1;
  logic [IA_W:0]        ins_len = '0;
  logic [DA_W:0]        data_len = '0;
  logic [DA_W-1:0]      res_base = '0;
  logic [DA_W:0]        res_len = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [DATA_W-1:0]    out_data;
  logic                 proc_start;
  logic                 proc_ready = 1'b1;
  logic                 proc_done;
  logic [IA_W-1:0]      proc_ins_addr;
  logic [DA_W-1:0]      proc_data_addr;
  logic [DATA_W-1:0]    proc_data_out;
  logic                 proc_wr_en;
  logic [IA_W-1:0]      ins_addr;
  logic                 ins_wr_en;
  logic [INS_WIDTH-1:0] ins_din;
  logic [DA_W-1:0]      data_addr;
  logic                 data_wr_en;
  logic [DATA_W-1:0]    data_din;
  logic [DATA_W-1:0]    data_dout;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     exec_cycles;

  always #5 clk = ~clk;

  system_sequencer #(
    .CORE_COUNT     (2),
    .REG_WIDTH      (12),
    .INS_WIDTH      (INS_WIDTH),
    .INS_MEM_DEPTH  (INS_MEM_DEPTH),
    .DATA_MEM_DEPTH (DATA_MEM_DEPTH),
    .CNT_W          (CNT_W)
  ) dut (
    .clk            (clk),
    .rstN           (rstN),
    .startN         (startN),
    .ins_len        (ins_len),
    .data_len       (data_len),
    .res_base       (res_base),
    .res_len        (res_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .proc_start     (proc_start),
    .proc_ready     (proc_ready),
    .proc_done      (proc_done),
    .proc_ins_addr  (proc_ins_addr),
    .proc_data_addr (proc_data_addr),
    .proc_data_out  (proc_data_out),
    .proc_wr_en     (proc_wr_en),
    .ins_addr       (ins_addr),
    .ins_wr_en      (ins_wr_en),
    .ins_din        (ins_din),
    .data_addr      (data_addr),
    .data_wr_en     (data_wr_en),
    .data_din       (data_din),
    .data_dout      (data_dout),
    .busy           (busy),
    .done           (done),
    .exec_cycles    (exec_cycles)
  );

  // Processor model: proc_done rises DONE_LAT cycles after the start pulse.
  int   run_cnt = 0;
  logic proc_wr_test = 1'b0;
  always @(posedge clk) begin
    if (!rstN)                    run_cnt <= 0;
    else if (proc_start)          run_cnt <= 1;
    else if (run_cnt == DONE_LAT) run_cnt <= 0;
    else if (run_cnt != 0)        run_cnt <= run_cnt + 1;
  end
  assign proc_done      = (run_cnt == DONE_LAT);
  assign proc_ins_addr  = IA_W'(run_cnt);
  assign proc_data_addr = 12'd3;
  assign proc_data_out  = 24'hABCDEF;
  assign proc_wr_en     = proc_wr_test && (run_cnt == 5);

  // Synchronous RAM models with one-cycle read latency.
  logic [INS_WIDTH-1:0] ins_mem  [INS_MEM_DEPTH];
  logic [DATA_W-1:0]    data_mem [DATA_MEM_DEPTH];
  logic                 preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DATA_MEM_DEPTH; i++) data_mem[i] <= 24'h5A0000 | 24'(i);
    end else if (data_wr_en) begin
      data_mem[data_addr] <= data_din;
    end
    if (ins_wr_en) ins_mem[ins_addr] <= ins_din;
    data_dout <= data_mem[data_addr];
  end

  int ins_wa[$];
  int data_wa[$];
  int pstart_n = 0;
  int ov_n     = 0;
  always @(negedge clk) begin
    if (ins_wr_en)              ins_wa.push_back(int'(ins_addr));
    if (data_wr_en && in_ready) data_wa.push_back(int'(data_addr));
    if (proc_start)             pstart_n++;
    if (out_valid)              ov_n++;
  end

  int n_cmp = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int il, input int dl, input int rb, input int rl);
    ins_len  = il[IA_W:0];
    data_len = dl[DA_W:0];
    res_base = rb[DA_W-1:0];
    res_len  = rl[DA_W:0];
    startN   = 1'b0;
    tick();
    startN   = 1'b1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("send_timeout", t, 0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_word(output logic [DATA_W-1:0] d, input int stall);
    int t = 0;
    logic [DATA_W-1:0] first;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("recv_timeout", t, 0);
    first = out_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, first);
    end
    d = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_reached", done, 1);
    tick();
  endtask

  logic [DATA_W-1:0] w;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    rstN    = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_proc_start", proc_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_exec", exec_cycles, 0);
    chk("rst_ins_we", ins_wr_en, 0);
    chk("rst_data_we", data_wr_en, 0);
    tick();

    // Full job; the processor overwrites data[3] mid-run.
    proc_wr_test = 1'b1;
    pstart_n = 0;
    ins_wa.delete();
    data_wa.delete();
    start_job(4, 3, 2, 2);
    chk("t1_busy", busy, 1);
    send_word(24'hFFFF11);
    send_word(24'hFFFF22);
    send_word(24'hFFFF33);
    send_word(24'hFFFF44);
    send_word(24'hA00001);
    send_word(24'hA00002);
    send_word(24'hA00003);
    recv_word(w, 0);
    chk("t1_out0", w, 24'hA00003);
    recv_word(w, 0);
    chk("t1_out1", w, 24'hABCDEF);
    wait_done(20);
    chk("t1_exec", exec_cycles, 10);
    chk("t1_pstart_n", pstart_n, 1);
    chk("t1_busy_fin", busy, 0);
    chk("t1_ins_wa_n", ins_wa.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_ins_wa", ins_wa[i], i);
    chk("t1_data_wa_n", data_wa.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_data_wa", data_wa[i], i);
    chk("t1_imem0", ins_mem[0], 8'h11);
    chk("t1_imem3", ins_mem[3], 8'h44);
    chk("t1_dmem0", data_mem[0], 24'hA00001);
    chk("t1_dmem2", data_mem[2], 24'hA00003);
    proc_wr_test = 1'b0;

    // All lengths zero: straight to EXEC_START, no dump.
    proc_ready = 1'b0;
    pstart_n = 0;
    ov_n = 0;
    start_job(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_busy", busy, 1);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_no_start", proc_start, 0);
    proc_ready = 1'b1;
    #1;
    chk("t2_pstart", proc_start, 1);
    begin
      int t = 0;
      @(negedge clk);
      while (!proc_done && t < 40) begin
        t++;
        @(negedge clk);
      end
      chk("t2_done_low", done, 0);
      @(negedge clk);
      chk("t2_done_next", done, 1);
    end
    chk("t2_ov_n", ov_n, 0);
    chk("t2_exec", exec_cycles, 10);
    chk("t2_pstart_n", pstart_n, 1);
    tick();

    // Gappy in_valid during LOAD_DATA.
    data_wa.delete();
    start_job(1, 2, 0, 0);
    send_word(24'h000055);
    in_valid = 1'b1; in_data = 24'h111111; tick();
    in_valid = 1'b0; in_data = 24'h999999; tick();
    in_valid = 1'b1; in_data = 24'h222222; tick();
    in_valid = 1'b0; tick();
    chk("t3_wa_n", data_wa.size(), 2);
    chk("t3_wa0", data_wa[0], 0);
    chk("t3_wa1", data_wa[1], 1);
    chk("t3_dmem0", data_mem[0], 24'h111111);
    chk("t3_dmem1", data_mem[1], 24'h222222);
    chk("t3_dmem2", data_mem[2], 24'hA00003);
    wait_done(40);

    // out_ready stall in DUMP_OUT.
    start_job(0, 0, 16, 2);
    recv_word(w, 5);
    chk("t4_out0", w, 24'h5A0010);
    recv_word(w, 0);
    chk("t4_out1", w, 24'h5A0011);
    wait_done(20);

    // Result region wrapping past the top of data RAM.
    start_job(0, 0, 4094, 3);
    recv_word(w, 0);
    chk("t5_out0", w, 24'h5A0FFE);
    recv_word(w, 0);
    chk("t5_out1", w, 24'h5A0FFF);
    recv_word(w, 0);
    chk("t5_out2", w, 24'h111111);
    wait_done(20);

    // Reset mid-LOAD_DATA, then reload from address 0.
    start_job(1, 3, 0, 0);
    send_word(24'h000066);
    send_word(24'h777777);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", in_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_exec", exec_cycles, 0);
    tick();
    data_wa.delete();
    start_job(0, 2, 0, 0);
    send_word(24'h333333);
    send_word(24'h444444);
    chk("t6_wa_n", data_wa.size(), 2);
    chk("t6_wa0", data_wa[0], 0);
    chk("t6_wa1", data_wa[1], 1);
    chk("t6_dmem0", data_mem[0], 24'h333333);
    chk("t6_dmem1", data_mem[1], 24'h444444);
    wait_done(40);
    chk("t6_exec_fin", exec_cycles, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
